// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port between NUM_REQ 4-phase req/ack clients.
// Optional HOLD-state stall release is compiled in with `define UART_ARB_HOLD_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_MAX  = 16,
   localparam int unsigned IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                             clock_i,
   input  logic                             reset_i,
   input  logic [NUM_REQ-1:0]               req_i,
   input  logic [NUM_REQ-1:0]               req_last_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
   output logic [NUM_REQ-1:0]               ack_o,
   output logic                             tx_pulse_o,
   output logic                             tx_wr_o,
   output logic [DATA_WIDTH-1:0]            tx_d_in_o,
   input  logic                             tx_full_i,
   output logic [IdW-1:0]                   grant_id_o,
   output logic                             busy_o
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StWrite = 2'd1;
   localparam logic [1:0] StAck   = 2'd2;
   localparam logic [1:0] StHold  = 2'd3;

   localparam logic [7:0] BurstMax = BURST_MAX[7:0];

   logic [1:0]            state_q, state_d;
   logic [IdW-1:0]        grant_q, grant_d;
   logic [IdW-1:0]        ptr_q, ptr_d;
   logic [7:0]            burst_q, burst_d;
   logic                  last_q, last_d;
   logic                  busy_q, busy_d;
   logic [NUM_REQ-1:0]    ack_q, ack_d;
   logic                  tx_wr_q, tx_wr_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

`ifdef UART_ARB_HOLD_TIMEOUT_EN
   localparam logic [15:0] HoldTimeout = 16'd1023;
   logic [15:0]           hold_cnt_q, hold_cnt_d;
`endif

   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
   logic [IdW-1:0]        sel;
   logic                  sel_valid;
   logic [IdW-1:0]        cand;
   logic [IdW-1:0]        grant_next;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // ptr_q holds the index where the next search starts, i.e. last_grant + 1.
   assign grant_next = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

   always_comb begin
      sel       = ptr_q;
      sel_valid = 1'b0;
      cand      = ptr_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IdW'((32'(ptr_q) + i) % NUM_REQ);
         if (!sel_valid && req_i[cand]) begin
            sel       = cand;
            sel_valid = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      burst_d   = burst_q;
      last_d    = last_q;
      busy_d    = busy_q;
      ack_d     = ack_q;
      tx_wr_d   = 1'b0;
      tx_data_d = tx_data_q;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (sel_valid) begin
               grant_d = sel;
               busy_d  = 1'b1;
               burst_d = '0;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (!req_i[grant_q]) begin
               busy_d  = 1'b0;
               ptr_d   = grant_next;
               state_d = StIdle;
            end else if (!tx_full_i) begin
               tx_wr_d   = 1'b1;
               tx_data_d = data_arr[grant_q];
               last_d    = req_last_i[grant_q];
               burst_d   = (burst_q == BurstMax) ? burst_q : burst_q + 8'd1;
               state_d   = StAck;
            end
         end
         StAck: begin
            ack_d = '0;
            if (req_i[grant_q]) begin
               ack_d[grant_q] = 1'b1;
            end else if (last_q || (burst_q == BurstMax)) begin
               busy_d  = 1'b0;
               ptr_d   = grant_next;
               state_d = StIdle;
            end else begin
`ifdef UART_ARB_HOLD_TIMEOUT_EN
               hold_cnt_d = '0;
`endif
               state_d = StHold;
            end
         end
         StHold: begin
            if (req_i[grant_q]) begin
               state_d = StWrite;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
            end else if (hold_cnt_q == HoldTimeout) begin
               busy_d  = 1'b0;
               ptr_d   = grant_next;
               state_d = StIdle;
            end else begin
               hold_cnt_d = hold_cnt_q + 16'd1;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         ptr_q     <= '0;
         burst_q   <= '0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         ack_q     <= '0;
         tx_wr_q   <= 1'b0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         burst_q   <= burst_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         tx_wr_q   <= tx_wr_d;
         tx_data_q <= tx_data_d;
      end
   end

`ifdef UART_ARB_HOLD_TIMEOUT_EN
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
`endif

   assign ack_o      = ack_q;
   assign tx_pulse_o = tx_wr_q;
   assign tx_wr_o    = tx_wr_q;
   assign tx_d_in_o  = tx_data_q;
   assign grant_id_o = grant_q;
   assign busy_o     = busy_q;

   a_ack_onehot: assert property (@(posedge clock_i) disable iff (reset_i) $onehot0(ack_o));
   a_no_wr_full: assert property (@(posedge clock_i) disable iff (reset_i) tx_wr_d |-> !tx_full_i);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed client traffic, expected bytes queued in grant order.
// The hold-timeout scenario runs only when UART_ARB_HOLD_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

   localparam int unsigned NumReq   = 4;
   localparam int unsigned Dw       = 8;
   localparam int unsigned BurstMax = 4;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic [NumReq-1:0]    req;
   logic [NumReq-1:0]    req_last;
   logic [NumReq*Dw-1:0] req_data;
   logic [NumReq-1:0]    ack;
   logic                 tx_pulse;
   logic                 tx_wr;
   logic [Dw-1:0]        tx_d_in;
   logic                 tx_full;
   logic [1:0]           grant_id;
   logic                 busy;
   logic                 full_at_edge = 1'b0;

   int checks   = 0;
   int failures = 0;

   logic [9:0] exp_q [$];

   logic [7:0] m_data  [NumReq][16];
   logic       m_last  [NumReq][16];
   int         m_cnt   [NumReq];
   int         m_pos   [NumReq];
   int         m_start [NumReq];
   int         m_phase [NumReq];
   int         tick_n;

   uart_tx_arbiter #(
      .NUM_REQ    (NumReq),
      .DATA_WIDTH (Dw),
      .BURST_MAX  (BurstMax)
   ) dut (
      .clock_i    (clock),
      .reset_i    (reset),
      .req_i      (req),
      .req_last_i (req_last),
      .req_data_i (req_data),
      .ack_o      (ack),
      .tx_pulse_o (tx_pulse),
      .tx_wr_o    (tx_wr),
      .tx_d_in_o  (tx_d_in),
      .tx_full_i  (tx_full),
      .grant_id_o (grant_id),
      .busy_o     (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) full_at_edge <= tx_full;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every UART write is matched against the next expected {client, byte}.
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (|ack) chk("ack_onehot", 32'($onehot0(ack)), 32'd1);
            if (tx_wr || tx_pulse) begin
               chk("pulse_eq_wr", 32'(tx_pulse), 32'(tx_wr));
               chk("wr_while_full", 32'(full_at_edge), 32'd0);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_write actual=%0h required=none", {grant_id, tx_d_in});
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_byte", 32'({grant_id, tx_d_in}), 32'(e));
               end
            end
         end
      end
   end

   task automatic model_clear();
      for (int c = 0; c < NumReq; c++) begin
         m_cnt[c]   = 0;
         m_pos[c]   = 0;
         m_start[c] = 0;
         m_phase[c] = 0;
      end
      tick_n   = 0;
      req      = '0;
      req_last = '0;
   endtask

   task automatic add_byte(input int c, input logic [7:0] d, input logic l);
      m_data[c][m_cnt[c]] = d;
      m_last[c][m_cnt[c]] = l;
      m_cnt[c]++;
   endtask

   function automatic bit all_done();
      bit r = 1'b1;
      for (int c = 0; c < NumReq; c++) begin
         if (m_pos[c] != m_cnt[c] || m_phase[c] != 0) r = 1'b0;
      end
      return r;
   endfunction

   // One negedge step of every client's 4-phase handshake.
   task automatic model_tick();
      @(negedge clock);
      tick_n++;
      for (int c = 0; c < NumReq; c++) begin
         case (m_phase[c])
            0: if (m_pos[c] < m_cnt[c] && tick_n >= m_start[c]) begin
               req_data[c*Dw +: Dw] = m_data[c][m_pos[c]];
               req_last[c]          = m_last[c][m_pos[c]];
               req[c]               = 1'b1;
               m_phase[c]           = 1;
            end
            1: if (ack[c]) begin
               req[c]     = 1'b0;
               m_phase[c] = 2;
            end
            default: if (!ack[c]) begin
               m_pos[c]++;
               m_phase[c] = 0;
            end
         endcase
      end
   endtask

   task automatic run_model(input string name, input int budget);
      int n = 0;
      while (n < budget && !(all_done() && exp_q.size() == 0 && !busy)) begin
         model_tick();
         n++;
      end
      chk(name, 32'(all_done() && exp_q.size() == 0 && !busy), 32'd1);
   endtask

   task automatic manual_send(input int c, input logic [7:0] d, input logic l, input string name);
      int n;
      req_data[c*Dw +: Dw] = d;
      req_last[c]          = l;
      req[c]               = 1'b1;
      n = 0;
      while (!ack[c] && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk({name, "_ack_hi"}, 32'(ack[c]), 32'd1);
      req[c] = 1'b0;
      n = 0;
      while (ack[c] && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk({name, "_ack_lo"}, 32'(ack[c]), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int wr_cnt;
      int ack_cnt;
      int n;
      req      = '0;
      req_last = '0;
      req_data = '0;
      tx_full  = 1'b0;
      model_clear();
      repeat (3) @(negedge clock);
      chk("reset_outputs", 32'({ack, tx_wr, tx_pulse, tx_d_in, grant_id, busy}), 32'd0);
      reset = 1'b0;

      // Single byte from client 0: write on the second edge, then ack.
      exp_q.push_back({2'd0, 8'hA5});
      req_data[7:0] = 8'hA5;
      req_last[0]   = 1'b1;
      req[0]        = 1'b1;
      @(negedge clock);
      chk("t1_no_wr_edge1", 32'(tx_wr), 32'd0);
      chk("t1_busy_owner", 32'({busy, grant_id}), 32'b100);
      @(negedge clock);
      chk("t1_wr_edge2", 32'(tx_wr), 32'd1);
      chk("t1_data", 32'(tx_d_in), 32'hA5);
      chk("t1_no_early_ack", 32'(ack), 32'd0);
      @(negedge clock);
      chk("t1_ack_hi", 32'(ack), 32'b0001);
      chk("t1_wr_one_cycle", 32'(tx_wr), 32'd0);
      req[0] = 1'b0;
      @(negedge clock);
      chk("t1_ack_lo", 32'(ack), 32'd0);
      chk("t1_idle", 32'(busy), 32'd0);
      chk("t1_data_hold", 32'(tx_d_in), 32'hA5);

      // All four clients at once, twice: order 0,1,2,3 both times.
      do_reset();
      for (int r = 0; r < 2; r++) begin
         model_clear();
         for (int c = 0; c < NumReq; c++) add_byte(c, 8'h10 + 8'(c), 1'b1);
         for (int c = 0; c < NumReq; c++) exp_q.push_back({2'(c), 8'h10 + 8'(c)});
         run_model("t2_done", 200);
      end

      // Three-byte message from client 1 is not interleaved with client 2.
      model_clear();
      add_byte(1, 8'h01, 1'b0);
      add_byte(1, 8'h02, 1'b0);
      add_byte(1, 8'h03, 1'b1);
      add_byte(2, 8'h20, 1'b1);
      exp_q.push_back({2'd1, 8'h01});
      exp_q.push_back({2'd1, 8'h02});
      exp_q.push_back({2'd1, 8'h03});
      exp_q.push_back({2'd2, 8'h20});
      run_model("t3_done", 200);

      // Burst limit of 4 forces rotation to waiting client 3 mid-message.
      model_clear();
      for (int i = 0; i < 6; i++) add_byte(0, 8'hB0 + 8'(i), i == 5);
      add_byte(3, 8'hE0, 1'b1);
      m_start[3] = 4;
      for (int i = 0; i < 4; i++) exp_q.push_back({2'd0, 8'hB0 + 8'(i)});
      exp_q.push_back({2'd3, 8'hE0});
      exp_q.push_back({2'd0, 8'hB4});
      exp_q.push_back({2'd0, 8'hB5});
      run_model("t4_done", 300);

      // FIFO full stalls the write; release gives exactly one write one edge later.
      model_clear();
      tx_full = 1'b1;
      exp_q.push_back({2'd2, 8'hC3});
      req_data[2*Dw +: Dw] = 8'hC3;
      req_last[2]          = 1'b1;
      req[2]               = 1'b1;
      wr_cnt  = 0;
      ack_cnt = 0;
      repeat (50) begin
         @(negedge clock);
         if (tx_wr) wr_cnt++;
         if (ack[2]) ack_cnt++;
      end
      chk("t5_no_write", 32'(wr_cnt), 32'd0);
      chk("t5_no_ack", 32'(ack_cnt), 32'd0);
      chk("t5_owner", 32'({busy, grant_id}), 32'b110);
      tx_full = 1'b0;
      @(negedge clock);
      chk("t5_wr_after_release", 32'(tx_wr), 32'd1);
      chk("t5_data", 32'(tx_d_in), 32'hC3);
      @(negedge clock);
      chk("t5_single_wr", 32'(tx_wr), 32'd0);
      chk("t5_ack_hi", 32'(ack), 32'b0100);
      req[2] = 1'b0;
      @(negedge clock);
      chk("t5_ack_lo", 32'(ack), 32'd0);

      // Asynchronous reset while client 1 is in its ack phase.
      exp_q.push_back({2'd1, 8'h77});
      req_data[1*Dw +: Dw] = 8'h77;
      req_last[1]          = 1'b1;
      req[1]               = 1'b1;
      n = 0;
      while (!ack[1] && n < 10) begin
         @(negedge clock);
         n++;
      end
      chk("t6_in_ack", 32'(ack), 32'b0010);
      reset = 1'b1;
      #1;
      chk("t6_async_clear", 32'({ack, tx_wr, tx_pulse, tx_d_in, grant_id, busy}), 32'd0);
      @(negedge clock);
      req[1] = 1'b0;
      reset  = 1'b0;
      exp_q.push_back({2'd1, 8'h5C});
      manual_send(1, 8'h5C, 1'b1, "t6_fresh");
      chk("t6_idle", 32'(busy), 32'd0);

`ifdef UART_ARB_HOLD_TIMEOUT_EN
      // Client 0 goes silent mid-message; grant is released after 1024 idle cycles.
      model_clear();
      add_byte(0, 8'h40, 1'b0);
      add_byte(2, 8'h42, 1'b1);
      m_start[2] = 4;
      exp_q.push_back({2'd0, 8'h40});
      exp_q.push_back({2'd2, 8'h42});
      n = 0;
      while (m_pos[0] < 1 && n < 40) begin
         model_tick();
         n++;
      end
      chk("t7_hold_entered", 32'(m_pos[0]), 32'd1);
      n = 0;
      while (busy && grant_id == 2'd0 && n < 1100) begin
         model_tick();
         n++;
      end
      chk("t7_hold_len", 32'(n >= 1020 && n <= 1030), 32'd1);
      run_model("t7_done", 100);
`endif

      repeat (3) @(negedge clock);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
